// File: rtl/mix_pkg.sv
// Shared MIX definitions: word geometry, opcodes and sequencer state encoding.
package mix_pkg;

    localparam int WORD_W   = 31;
    localparam int BYTE_W   = 6;
    localparam int SIGN_BIT = 30;
    localparam int NBYTES   = 5;
    localparam int MAG_W    = WORD_W - 1;

    localparam logic [5:0] OP_DIV = 6'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT_MEM,
        S_LAUNCH,
        S_WAIT_DIV,
        S_WB,
        S_ERR
    } div_state_t;

endpackage

// File: rtl/field_extract.sv
// MIX field spec (L:R) applied to a word: right-aligned bytes max(L,1)..R,
// sign kept only when L = 0, plus a legality flag (L <= R <= 5).
module field_extract
    import mix_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [2:0]        l,
    input  logic [2:0]        r,
    output logic              sign,
    output logic [MAG_W-1:0]  mag,
    output logic              legal
);

    logic [2:0]       lo;
    logic [31:0]      sh;
    logic [31:0]      nb;
    logic [MAG_W-1:0] mask;

    // Shift byte R down to the bottom, then keep only the selected byte count.
    always_comb begin
        legal = (l <= r) && (r <= 3'(NBYTES));
        lo    = (l == 3'd0) ? 3'd1 : l;
        sh    = '0;
        nb    = '0;
        if (legal) begin
            sh = 32'(BYTE_W) * (32'(NBYTES) - 32'(r));
            if (r >= lo) begin
                nb = 32'(r) - 32'(lo) + 32'd1;
            end
        end
        mask = ~({MAG_W{1'b1}} << (32'(BYTE_W) * nb));
        mag  = (word[MAG_W-1:0] >> sh) & mask;
        sign = legal && (l == 3'd0) && word[SIGN_BIT];
    end

endmodule

// File: rtl/div_seq.sv
// MIX DIV sequencer: fetch V, apply field, launch div, write back rA/rX.
module div_seq
    import mix_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] addr,
    input  logic [5:0]    field,
    input  logic [30:0]   ra_in,
    input  logic [30:0]   rx_in,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic          mem_valid,
    input  logic [30:0]   mem_data,
    output logic          div_start,
    output logic [60:0]   div_dividend,
    output logic [30:0]   div_divisor,
    input  logic          div_stop,
    input  logic [29:0]   div_quotient,
    input  logic [29:0]   div_rest,
    input  logic          div_sign,
    input  logic          div_overflow,
    output logic [30:0]   ra_out,
    output logic [30:0]   rx_out,
    output logic          ra_we,
    output logic          rx_we,
    output logic          ovf_set,
    output logic          field_err,
    output logic          busy,
    output logic          done
);

    div_state_t  state;
    logic [5:0]  field_q;
    logic [2:0]  fx_l;
    logic [2:0]  fx_r;
    logic        fx_sign;
    logic [29:0] fx_mag;
    logic        fx_legal;
    logic        unused_rx_sign;

    // The rX sign never reaches div: only its magnitude forms the low dividend half.
    assign unused_rx_sign = rx_in[30];

    // One extractor serves both jobs: in IDLE it judges the incoming F for
    // legality; afterwards it applies the latched F to the memory word.
    assign fx_l = (state == S_IDLE) ? field[5:3] : field_q[5:3];
    assign fx_r = (state == S_IDLE) ? field[2:0] : field_q[2:0];

    field_extract u_fx (
        .word  (mem_data),
        .l     (fx_l),
        .r     (fx_r),
        .sign  (fx_sign),
        .mag   (fx_mag),
        .legal (fx_legal)
    );

    // Sequencer FSM; every output is a register updated on state transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            field_q      <= '0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            ra_out       <= '0;
            rx_out       <= '0;
            ra_we        <= 1'b0;
            rx_we        <= 1'b0;
            ovf_set      <= 1'b0;
            field_err    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            mem_rd    <= 1'b0;
            div_start <= 1'b0;
            ra_we     <= 1'b0;
            rx_we     <= 1'b0;
            ovf_set   <= 1'b0;
            field_err <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mem_addr     <= addr;
                        field_q      <= field;
                        div_dividend <= {ra_in[30], ra_in[29:0], rx_in[29:0]};
                        busy         <= 1'b1;
                        if (fx_legal) begin
                            state  <= S_READ;
                            mem_rd <= 1'b1;
                        end else begin
                            state     <= S_ERR;
                            done      <= 1'b1;
                            field_err <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    state <= S_WAIT_MEM;
                end
                S_WAIT_MEM: begin
                    if (mem_valid) begin
                        div_divisor <= {fx_sign, fx_mag};
                        div_start   <= 1'b1;
                        state       <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT_DIV;
                end
                S_WAIT_DIV: begin
                    if (div_stop) begin
                        done  <= 1'b1;
                        state <= S_WB;
                        if (div_overflow) begin
                            ovf_set <= 1'b1;
                        end else begin
                            ra_out <= {div_sign, div_quotient};
                            rx_out <= {div_dividend[60], div_rest};
                            ra_we  <= 1'b1;
                            rx_we  <= 1'b1;
                        end
                    end
                end
                S_WB, S_ERR: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq with behavioural memory and div unit models.
module tb_div_seq;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] addr;
    logic [5:0]    field;
    logic [30:0]   ra_in, rx_in;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_valid;
    logic [30:0]   mem_data;
    logic          div_start;
    logic [60:0]   div_dividend;
    logic [30:0]   div_divisor;
    logic          div_stop;
    logic [29:0]   div_quotient, div_rest;
    logic          div_sign, div_overflow;
    logic [30:0]   ra_out, rx_out;
    logic          ra_we, rx_we, ovf_set, field_err, busy, done;

    div_seq #(.AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .addr         (addr),
        .field        (field),
        .ra_in        (ra_in),
        .rx_in        (rx_in),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_valid    (mem_valid),
        .mem_data     (mem_data),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_stop     (div_stop),
        .div_quotient (div_quotient),
        .div_rest     (div_rest),
        .div_sign     (div_sign),
        .div_overflow (div_overflow),
        .ra_out       (ra_out),
        .rx_out       (rx_out),
        .ra_we        (ra_we),
        .rx_we        (rx_we),
        .ovf_set      (ovf_set),
        .field_err    (field_err),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          illegal;
        bit          ovf;
        logic [30:0] ra;
        logic [30:0] rx;
        logic [60:0] dvd;
        logic [30:0] dvs;
        int          lat;
        logic [11:0] addr;
        int          start_cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_rd = 0;
    int          n_ds = 0;
    logic [30:0] cur_word;
    int          cur_memlat = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Field spec by byte arithmetic: value = concatenation of bytes max(L,1)..R in base 64.
    function automatic void ref_v(input logic [30:0] w, input int f,
                                  output bit legal, output bit s, output longint unsigned m);
        int l = f / 8;
        int r = f % 8;
        longint unsigned wm = longint'(w[29:0]);
        legal = (l <= r) && (r <= 5);
        m = 0;
        s = 1'b0;
        if (legal) begin
            for (int b = (l == 0) ? 1 : l; b <= r; b++)
                m = m * 64 + ((wm / (64 ** (5 - b))) % 64);
            s = (l == 0) ? w[30] : 1'b0;
        end
    endfunction

    // MIX DIV semantics on signed-magnitude words.
    function automatic exp_t make_exp(input logic [30:0] ra, input logic [30:0] rx,
                                      input logic [30:0] w, input int f);
        exp_t e;
        bit legal, s;
        longint unsigned vm, am, dm, q, rm;
        ref_v(w, f, legal, s, vm);
        am = longint'(ra[29:0]);
        dm = am * (64'd1 << 30) + longint'(rx[29:0]);
        e.illegal = !legal;
        e.dvd = {ra[30], ra[29:0], rx[29:0]};
        e.dvs = {s, vm[29:0]};
        e.ovf = legal && (vm == 0 || am >= vm);
        e.ra = '0;
        e.rx = '0;
        if (legal && !e.ovf) begin
            q = dm / vm;
            rm = dm % vm;
            e.ra = {ra[30] ^ s, q[29:0]};
            e.rx = {ra[30], rm[29:0]};
        end
        e.lat = 0;
        e.addr = '0;
        e.start_cyc = 0;
        return e;
    endfunction

    // Memory: answer each read after cur_memlat cycles; noise on mem_valid otherwise.
    initial begin
        mem_valid = 1'b0;
        mem_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_rd === 1'b1) begin
                if (exp_q.size() == 0) chk("mem_rd_unexpected", 64'(1), 64'(0));
                else chk("mem_addr", 64'(mem_addr), 64'(exp_q[0].addr));
                mem_valid = 1'($urandom);
                mem_data  = 31'($urandom);
                repeat (cur_memlat - 1) begin
                    @(posedge clk); #1;
                    mem_valid = 1'b0;
                end
                @(posedge clk); #1;
                mem_valid = 1'b1;
                mem_data  = cur_word;
            end else begin
                mem_valid = (($urandom % 4) == 0);
                mem_data  = 31'($urandom);
            end
        end
    end

    // div unit: 12 cycles start->stop, no reset, so an orphaned run still emits stop.
    initial begin
        int          cnt = 0;
        logic [60:0] dd;
        logic [30:0] dv;
        longint unsigned dm, vm;
        div_stop = 1'b0;
        div_quotient = '0;
        div_rest = '0;
        div_sign = 1'b0;
        div_overflow = 1'b0;
        dd = '0;
        dv = '0;
        forever begin
            @(posedge clk); #1;
            div_stop = 1'b0;
            if (div_start === 1'b1) begin
                dd = div_dividend;
                dv = div_divisor;
                if (exp_q.size() == 0) chk("div_start_unexpected", 64'(1), 64'(0));
                else begin
                    chk("div_dividend", 64'(dd), 64'(exp_q[0].dvd));
                    chk("div_divisor", 64'(dv), 64'(exp_q[0].dvs));
                end
                cnt = 12;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    dm = longint'(dd[59:0]);
                    vm = longint'(dv[29:0]);
                    div_stop = 1'b1;
                    div_sign = dd[60] ^ dv[30];
                    div_overflow = (vm == 0) || (longint'(dd[59:30]) >= vm);
                    if (div_overflow) begin
                        div_quotient = 30'($urandom);
                        div_rest = 30'($urandom);
                    end else begin
                        div_quotient = 30'(dm / vm);
                        div_rest = 30'(dm % vm);
                    end
                end
            end
        end
    end

    // Monitor: count request pulses and check each completion against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            n_rd = 0;
            n_ds = 0;
        end else begin
            if (mem_rd) n_rd++;
            if (div_start) n_ds++;
            if (done) begin
                if (exp_q.size() == 0) chk("unexpected_done", 64'(1), 64'(0));
                else begin
                    mon_e = exp_q.pop_front();
                    chk("latency", 64'(cyc - mon_e.start_cyc), 64'(mon_e.lat));
                    chk("busy_at_done", 64'(busy), 64'(1));
                    chk("field_err", 64'(field_err), 64'(mon_e.illegal));
                    chk("ovf_set", 64'(ovf_set), 64'(mon_e.ovf));
                    chk("ra_we", 64'(ra_we), 64'(!mon_e.illegal && !mon_e.ovf));
                    chk("rx_we", 64'(rx_we), 64'(!mon_e.illegal && !mon_e.ovf));
                    chk("mem_rd_count", 64'(n_rd), 64'(mon_e.illegal ? 0 : 1));
                    chk("div_start_count", 64'(n_ds), 64'(mon_e.illegal ? 0 : 1));
                    if (!mon_e.illegal && !mon_e.ovf) begin
                        chk("ra_out", 64'(ra_out), 64'(mon_e.ra));
                        chk("rx_out", 64'(rx_out), 64'(mon_e.rx));
                    end
                end
                n_rd = 0;
                n_ds = 0;
            end else if (ra_we || rx_we || ovf_set || field_err) begin
                chk("stray_pulse", 64'(1), 64'(0));
            end
        end
    end

    task automatic chk_reset_state();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_mem_rd", 64'(mem_rd), 64'(0));
        chk("rst_div_start", 64'(div_start), 64'(0));
        chk("rst_we", 64'({ra_we, rx_we, ovf_set, field_err}), 64'(0));
        chk("rst_ra_out", 64'(ra_out), 64'(0));
        chk("rst_rx_out", 64'(rx_out), 64'(0));
        chk("rst_dividend", 64'(div_dividend), 64'(0));
        chk("rst_divisor", 64'(div_divisor), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    endtask

    // Called just after a rising edge; drives a one-cycle start and records the expectation.
    task automatic issue(input logic [30:0] ra, input logic [30:0] rx,
                         input logic [30:0] w, input int f, input int ml);
        exp_t e;
        logic [11:0] a;
        a = 12'($urandom);
        e = make_exp(ra, rx, w, f);
        e.addr = a;
        e.lat = e.illegal ? 1 : 15 + ml;
        e.start_cyc = cyc;
        cur_word = w;
        cur_memlat = ml;
        exp_q.push_back(e);
        start = 1'b1;
        addr = a;
        field = 6'(f);
        ra_in = ra;
        rx_in = rx;
        @(posedge clk); #1;
        start = 1'b0;
        addr = 12'($urandom);
        field = 6'($urandom);
        ra_in = 31'($urandom);
        rx_in = 31'($urandom);
        chk("busy_after_start", 64'(busy), 64'(1));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", 64'(0), 64'(1));
            exp_q.delete();
        end
    endtask

    task automatic run_op(input logic [30:0] ra, input logic [30:0] rx,
                          input logic [30:0] w, input int f, input int ml, input bit poke);
        issue(ra, rx, w, f, ml);
        if (poke) begin
            repeat (2) begin @(posedge clk); #1; end
            start = 1'b1;
            field = 6'($urandom);
            ra_in = 31'($urandom);
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    localparam logic [30:0] NEG_ZERO = 31'h4000_0000;
    localparam logic [30:0] BYTES12345 = 31'((1 << 24) | (2 << 18) | (3 << 12) | (4 << 6) | 5);

    initial begin
        logic [30:0] w, ra, rx;
        int f, l, r;
        bit legal, s;
        longint unsigned vm;
        reset = 1'b1;
        start = 1'b0;
        addr = '0;
        field = '0;
        ra_in = '0;
        rx_in = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_reset_state();

        run_op(31'd0, 31'd17, 31'd3, 5, 1, 1'b0);
        run_op(NEG_ZERO, 31'd1235, 31'd200, 5, 1, 1'b0);
        run_op(31'd0, 31'd522, BYTES12345, 37, 1, 1'b0);
        run_op(31'd0, 31'd99, 31'd0, 5, 1, 1'b0);
        run_op(31'd5, 31'd0, 31'd5, 5, 2, 1'b0);
        run_op(31'd0, 31'd7, NEG_ZERO | 31'd9, 0, 1, 1'b0);
        run_op(31'd0, 31'd17, 31'd3, 26, 1, 1'b0);
        run_op(31'd0, 31'd17, 31'd3, 5, 3, 1'b1);

        // Abort during WAIT_DIV with start held alongside reset; the orphaned
        // div stop lands while the next DIV is still waiting on memory.
        issue(31'd1, 31'd2, 31'd7, 5, 1);
        repeat (5) begin @(posedge clk); #1; end
        reset = 1'b1;
        start = 1'b1;
        field = 6'd5;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        chk_reset_state();
        run_op(31'd0, 31'd17, 31'd3, 5, 10, 1'b0);

        for (int i = 0; i < 40; i++) begin
            w = 31'($urandom);
            if (($urandom % 8) == 0) f = int'($urandom % 64);
            else begin
                r = int'($urandom_range(0, 5));
                l = int'($urandom_range(0, r));
                f = 8 * l + r;
            end
            ref_v(w, f, legal, s, vm);
            if (vm == 0 || ($urandom % 6) == 0) ra = 31'($urandom);
            else ra = {1'($urandom), 30'(longint'($urandom) % vm)};
            rx = 31'($urandom);
            run_op(ra, rx, w, f, int'($urandom_range(1, 4)), legal && (($urandom % 3) == 0));
        end

        repeat (20) @(posedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
